// File: rtl/shift_sequencer.sv
// Multi-cycle shift-by-N controller: one 1-bit shift stage per clock, sticky overflow.
// Optional arithmetic-right mode and `dir` port enabled by defining SHIFT_SEQ_ASR_EN.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amt,
`ifdef SHIFT_SEQ_ASR_EN
    input  logic             dir,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic             ovf_nxt;
    logic [AMT_W-1:0] cnt, cnt_nxt;
`ifdef SHIFT_SEQ_ASR_EN
    logic             dir_q, dir_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
            ovf    <= 1'b0;
            cnt    <= '0;
`ifdef SHIFT_SEQ_ASR_EN
            dir_q  <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            result <= result_nxt;
            ovf    <= ovf_nxt;
            cnt    <= cnt_nxt;
`ifdef SHIFT_SEQ_ASR_EN
            dir_q  <= dir_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        result_nxt = result;
        ovf_nxt    = ovf;
        cnt_nxt    = cnt;
`ifdef SHIFT_SEQ_ASR_EN
        dir_nxt    = dir_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    result_nxt = operand;
                    cnt_nxt    = amt;
                    ovf_nxt    = 1'b0;
`ifdef SHIFT_SEQ_ASR_EN
                    dir_nxt    = dir;
`endif
                    state_nxt  = (amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
`ifdef SHIFT_SEQ_ASR_EN
                if (dir_q) begin
                    ovf_nxt    = ovf | result[0];
                    result_nxt = {result[WIDTH-1], result[WIDTH-1:1]};
                end else begin
                    ovf_nxt    = ovf | result[WIDTH-1];
                    result_nxt = {result[WIDTH-2:0], 1'b0};
                end
`else
                ovf_nxt    = ovf | result[WIDTH-1];
                result_nxt = {result[WIDTH-2:0], 1'b0};
`endif
                cnt_nxt = cnt - AMT_W'(1);
                // Exit on the last shift so cnt never wraps below zero
                if (cnt == AMT_W'(1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized operations
// scored against an arithmetic reference model.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] operand;
    logic [3:0]  amt;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;
`ifdef SHIFT_SEQ_ASR_EN
    logic        dir;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .operand (operand),
        .amt     (amt),
`ifdef SHIFT_SEQ_ASR_EN
        .dir     (dir),
`endif
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Shift-by-N as one arithmetic step: left uses a wide product, right uses >>>
    function automatic void model(input logic [15:0] op, input int a, input logic d,
                                  output logic [15:0] r, output logic o);
        logic [31:0] w;
        logic [15:0] mask;
        if (!d) begin
            w = {16'h0, op} << a;
            r = w[15:0];
            o = |w[31:16];
        end else begin
            r    = 16'($signed(op) >>> a);
            mask = 16'((32'd1 << a) - 32'd1);
            o    = |(op & mask);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [15:0] op, input logic [3:0] a,
                          input logic d, input bit poke);
        logic [15:0] er;
        logic        eo;
        int          k;
        model(op, int'(a), d, er, eo);
        operand = op;
        amt     = a;
`ifdef SHIFT_SEQ_ASR_EN
        dir     = d;
`endif
        start   = 1'b1;
        tick();
        start   = 1'b0;
        operand = 16'($urandom);
        amt     = 4'($urandom);
        check({tag, ".busy_rise"}, 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 40) begin
            if (poke && k == 1) begin
                operand = 16'h00FF;
                amt     = 4'd2;
                start   = 1'b1;
            end
            tick();
            start = 1'b0;
            k++;
        end
        check({tag, ".latency"}, 32'(k), 32'(a));
        check({tag, ".result"}, 32'(result), 32'(er));
        check({tag, ".ovf"}, 32'(ovf), 32'(eo));
        tick();
        check({tag, ".busy_fall"}, 32'({busy, done}), 32'd0);
        check({tag, ".held"}, 32'({ovf, result}), 32'({eo, er}));
    endtask

    initial begin
        logic [15:0] rop;
        logic [3:0]  ramt;
        logic        rdir;
        int          ndone;

        reset   = 1'b1;
        start   = 1'b0;
        operand = '0;
        amt     = '0;
`ifdef SHIFT_SEQ_ASR_EN
        dir     = 1'b0;
`endif
        tick();
        tick();
        check("reset.outputs", 32'({busy, done, ovf, result}), 32'd0);
        reset = 1'b0;
        tick();
        check("idle.hold", 32'({busy, done, ovf, result}), 32'd0);

        run_op("d_0c_1", 16'h000C, 4'd1, 1'b0, 1'b0);
        check("d_0c_1.value", 32'(result), 32'h0018);
        run_op("d_ffff_4", 16'hFFFF, 4'd4, 1'b0, 1'b0);
        check("d_ffff_4.value", 32'({ovf, result}), 32'h1FFF0);
        run_op("d_fffb_1", 16'hFFFB, 4'd1, 1'b0, 1'b0);
        check("d_fffb_1.value", 32'({ovf, result}), 32'h1FFF6);
        run_op("d_amt0", 16'h1234, 4'd0, 1'b0, 1'b0);
        check("d_amt0.value", 32'({ovf, result}), 32'h01234);
        run_op("d_amt15", 16'h0001, 4'd15, 1'b0, 1'b0);
        check("d_amt15.value", 32'({ovf, result}), 32'h08000);
        run_op("d_amt15_all", 16'hFFFF, 4'd15, 1'b0, 1'b0);
        run_op("d_ignored_start", 16'hFFFF, 4'd4, 1'b0, 1'b1);
        check("d_ignored_start.value", 32'({ovf, result}), 32'h1FFF0);
`ifdef SHIFT_SEQ_ASR_EN
        run_op("d_asr", 16'h8004, 4'd3, 1'b1, 1'b0);
        check("d_asr.value", 32'({ovf, result}), 32'h1F000);
`endif

        // Reset partway through an amt=8 operation
        operand = 16'h00F3;
        amt     = 4'd8;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset.outputs", 32'({busy, done, ovf, result}), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        check("midreset.no_done", 32'(ndone), 32'd0);

        // start coincident with reset is not accepted
        operand = 16'h1234;
        amt     = 4'd3;
        reset   = 1'b1;
        start   = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("reset_start.outputs", 32'({busy, done, ovf, result}), 32'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        check("reset_start.no_op", 32'(ndone), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rop  = 16'($urandom);
            ramt = 4'($urandom);
`ifdef SHIFT_SEQ_ASR_EN
            rdir = 1'($urandom);
`else
            rdir = 1'b0;
`endif
            run_op($sformatf("rand%0d", i), rop, ramt, rdir, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
